adder_n: RTL and testbench
==========================

// Module: adder_n
// PURPOSE
//   Registered N-bit binary adder with carry-in/carry-out: sum = a + b + cin.
//   Carry-lookahead datapath built from 4-bit CLA groups chained by group carry.
//   One-cycle latency; used as a generic arithmetic leaf block in datapaths.
// PARAMETERS
//   WIDTH  16  operand/sum width in bits; must be a multiple of 4, >= 4
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands valid this cycle
//   a          in   WIDTH  operand A, unsigned
//   b          in   WIDTH  operand B, unsigned
//   cin        in   1      carry-in
//   sum        out  WIDTH  registered result, low WIDTH bits of a+b+cin
//   cout       out  1      registered carry-out, bit WIDTH of a+b+cin
//   out_valid  out  1      sum/cout hold a fresh result
//   ovf        out  1      signed overflow; present only with ADDER_N_OVF_EN
// BEHAVIOUR
//   - Clocking: one clock domain (clk); synchronous, active-high reset (rst).
//   - Reset: rst=1 at rising edge -> sum=0, cout=0, out_valid=0 (ovf=0).
//     rst dominates in_valid in the same cycle; an in-flight result is discarded.
//   - Latency 1: operands sampled at edge k with in_valid=1 -> sum/cout
//     valid after edge k, out_valid=1 for exactly that cycle.
//   - in_valid=0: sum/cout hold last value; out_valid=0 next cycle.
//   - Back-to-back: in_valid high every cycle -> one result per cycle, no stall.
//   - Arithmetic: {cout,sum} = a + b + cin, full WIDTH+1-bit exact result,
//     no saturation; wraps modulo 2^WIDTH with cout signalling carry.
//   - Datapath: per bit g=a&b, p=a^b; 4-bit CLA group computes
//     c[i+1]=g[i]|p[i]&c[i] in lookahead form, group G/P; group carries
//     rippled between groups; sum[i]=p[i]^c[i]. Purely combinational
//     before the output register; no latches.
//   - X/undefined inputs while in_valid=0 must not affect outputs.
// CONFIGURATION
//   ADDER_N_OVF_EN defined: port ovf present; ovf registered alongside sum,
//     ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]) (two's-complement
//     overflow), reset to 0, updates only when in_valid=1.
//   ADDER_N_OVF_EN undefined: port ovf absent; no overflow logic.
// TESTING  (WIDTH=16, one result checked one cycle after each sample)
//   rst=1 two cycles -> sum=0x0000, cout=0, out_valid=0.
//   a=0x0001,b=0x0001,cin=0 -> sum=0x0002, cout=0, out_valid=1.
//   a=0xFFFF,b=0x0000,cin=1 -> sum=0x0000, cout=1 (full carry chain).
//   a=0xFFFF,b=0xFFFF,cin=1 -> sum=0xFFFF, cout=1.
//   a=0x7FFF,b=0x0001,cin=0 -> sum=0x8000, cout=0, ovf=1 if ADDER_N_OVF_EN.
//   in_valid pulse then rst=1 next edge -> out_valid=0, sum=0; then
//     1000 random triples vs reference {cout,sum}=a+b+cin, zero mismatches.

Source files
------------

// File: rtl/adder_n.sv
// Registered WIDTH-bit adder {cout,sum} = a + b + cin built from 4-bit carry-lookahead groups.
// Optional signed-overflow output ovf is enabled by defining ADDER_N_OVF_EN.
module adder_n #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
`ifdef ADDER_N_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NGRP = WIDTH / 4;

    // Returns {group carry-out, c3, c2, c1, c0}; every carry is in two-level lookahead form.
    function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        logic c1, c2, c3, gg, pp;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pp = &p;
        return {gg | (pp & ci), c3, c2, c1, ci};
    endfunction

    logic [WIDTH-1:0] g_w;
    logic [WIDTH-1:0] p_w;
    logic [WIDTH:0]   carry_w;
    logic [4:0]       grp_w;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             vld_q;

    always_comb begin
        g_w        = a & b;
        p_w        = a ^ b;
        grp_w      = '0;
        carry_w    = '0;
        carry_w[0] = cin;
        // Group carries ripple from one CLA group into the next.
        for (int i = 0; i < NGRP; i++) begin
            grp_w                = cla4(g_w[4*i +: 4], p_w[4*i +: 4], carry_w[4*i]);
            carry_w[4*i+1 +: 3]  = grp_w[3:1];
            carry_w[4*i+4]       = grp_w[4];
        end
        sum_d  = p_w ^ carry_w[WIDTH-1:0];
        cout_d = carry_w[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = vld_q;

`ifdef ADDER_N_OVF_EN
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_d[WIDTH-1] != a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (in_valid) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_n.sv
// Scoreboard bench for adder_n: driver pushes expected per-cycle outputs, monitor pops and compares.
module tb_adder_n;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         out_valid;
`ifdef ADDER_N_OVF_EN
    logic         ovf;
`endif

    adder_n #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
`ifdef ADDER_N_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         vld;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        string        tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: what the outputs must show after the next edge.
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [W-1:0] ta,
                        input logic [W-1:0] tb_b, input logic tc, input string tag);
        exp_t        e;
        int unsigned full;
        rst      = r;
        in_valid = v;
        a        = ta;
        b        = tb_b;
        cin      = tc;
        if (r) begin
            m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
            e.vld = 1'b0;
        end else if (v) begin
            full   = int'(ta) + int'(tb_b) + int'(tc);
            m_sum  = full[W-1:0];
            m_cout = full[W];
            m_ovf  = ($signed(ta) >= 0) == ($signed(tb_b) >= 0) &&
                     (($signed(m_sum) >= 0) != ($signed(ta) >= 0));
            e.vld  = 1'b1;
        end else begin
            e.vld = 1'b0;
        end
        e.s = m_sum; e.co = m_cout; e.ov = m_ovf; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected record per clock edge, checked at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".out_valid"}, 32'(out_valid), 32'(e.vld));
            chk({e.tag, ".sum"}, 32'(sum), 32'(e.s));
            chk({e.tag, ".cout"}, 32'(cout), 32'(e.co));
`ifdef ADDER_N_OVF_EN
            chk({e.tag, ".ovf"}, 32'(ovf), 32'(e.ov));
`endif
        end
    end

    initial begin
        logic         r, v, c;
        logic [W-1:0] ra, rb;
        #1;
        step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, "reset0");
        step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, "reset1");
        step(1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0, "one_plus_one");
        step(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, "full_chain");
        step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "all_ones");
        step(1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b0, "signed_ovf");
        step(1'b0, 1'b0, 16'hDEAD, 16'hBEEF, 1'b1, "hold_idle");
        step(1'b0, 1'b1, 16'h1234, 16'h4321, 1'b0, "pulse");
        step(1'b1, 1'b0, 16'h5555, 16'hAAAA, 1'b1, "reset_after_pulse");
        step(1'b0, 1'b1, 16'h8000, 16'h8000, 1'b0, "neg_ovf");
        step(1'b1, 1'b1, 16'h0F0F, 16'hF0F0, 1'b1, "reset_dominates");
        step(1'b0, 1'b0, 16'h3C3C, 16'hC3C3, 1'b0, "idle_after_reset");
        for (int i = 0; i < 1000; i++) begin
            r  = ($urandom_range(0, 63) == 0);
            v  = ($urandom_range(0, 4) != 0);
            ra = W'($urandom);
            rb = W'($urandom);
            c  = 1'($urandom);
            step(r, v, ra, rb, c, "random");
        end
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, "drain");
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
